seg7_scan_display: RTL and testbench

//   Parametrised successor to the fixed 4-digit hex display: a time-multiplexed N-digit
//   7-segment hex driver with a double-buffered value, PWM brightness, inter-digit ghost

---
 rtl/seg7_scan_display.sv | 212 +++++++++++++++++++++
 tb/tb_seg7_scan_display.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// Time-multiplexed N-digit 7-segment hex display driver.
// A double-buffered value is scanned one digit per slot. Each slot is split
// into 16 substeps: substep 0 is always dark to suppress ghosting between
// digits, and the remaining substeps give PWM brightness control.
// Leading zeros can be blanked, and segment and digit polarity are parameters.
// All outputs are registered, so they follow the scan state by one cycle.
module seg7_scan_display #(
    parameter int DIGITS         = 4,
    parameter int CLK_HZ         = 12000000,
    parameter int SCAN_HZ        = 1000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  enable,
    input  logic                  blank_lz,
    input  logic [3:0]            brightness,
    output logic [6:0]            segment,
    output logic                  dp,
    output logic [DIGITS-1:0]     omask,
    output logic                  frame_done
);

    // Prescaler length: one tick per substep, never less than one cycle.
    localparam int DIV_RAW = CLK_HZ / (SCAN_HZ * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0]     PRE_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0]     DIG_LAST = DW'(DIGITS - 1);

    // Inactive levels. These are also XOR masks that convert the
    // active-high internal form into the pin polarity.
    localparam logic [6:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF   = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [DIGITS-1:0] DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Hex nibble to gfedcba segment pattern, active-high form.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    logic [PW-1:0]         prescale_r;
    logic [3:0]            substep_r;
    logic [DW-1:0]         digit_r;

    logic [4*DIGITS-1:0]   shadow_value_r;
    logic [DIGITS-1:0]     shadow_dp_r;
    logic [4*DIGITS-1:0]   active_value_r;
    logic [DIGITS-1:0]     active_dp_r;
    logic                  pending_r;

    logic                  tick_s;
    logic                  sub_wrap_s;
    logic                  frame_end_s;
    logic                  take_now_s;

    logic [3:0]            nibble_s;
    logic                  dp_bit_s;
    logic                  blanked_s;
    logic                  zero_above_s;
    logic [DIGITS-1:0]     sel_s;
    logic                  window_s;
    logic [6:0]            seg_next_s;
    logic                  dp_next_s;
    logic                  sel_on_s;

    // Scan timing strobes: substep tick, slot end and frame end.
    always_comb begin
        tick_s      = (prescale_r == PRE_LAST);
        sub_wrap_s  = tick_s && (substep_r == 4'hF);
        frame_end_s = sub_wrap_s && (digit_r == DIG_LAST);
        // The shadow may move to the active buffer at a frame boundary, or
        // at any time while the display is dark.
        take_now_s  = (!enable) || frame_end_s;
    end

    // Scan counters: prescaler -> substep -> digit. They are held at zero while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_r <= '0;
            substep_r  <= 4'h0;
            digit_r    <= '0;
        end else if (!enable) begin
            prescale_r <= '0;
            substep_r  <= 4'h0;
            digit_r    <= '0;
        end else begin
            if (tick_s) begin
                prescale_r <= '0;
                substep_r  <= substep_r + 4'h1;
            end else begin
                prescale_r <= prescale_r + PW'(1);
            end
            if (sub_wrap_s) begin
                if (digit_r == DIG_LAST) begin
                    digit_r <= '0;
                end else begin
                    digit_r <= digit_r + DW'(1);
                end
            end
        end
    end

    // Double buffer: load fills the shadow. The active copy changes only when the display cannot tear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_value_r <= '0;
            shadow_dp_r    <= '0;
            active_value_r <= '0;
            active_dp_r    <= '0;
            pending_r      <= 1'b0;
        end else begin
            if (load) begin
                shadow_value_r <= value;
                shadow_dp_r    <= dp_in;
            end
            if (take_now_s) begin
                if (load) begin
                    active_value_r <= value;
                    active_dp_r    <= dp_in;
                end else if (pending_r) begin
                    active_value_r <= shadow_value_r;
                    active_dp_r    <= shadow_dp_r;
                end
                pending_r <= 1'b0;
            end else if (load) begin
                pending_r <= 1'b1;
            end
        end
    end

    // Select the current digit, decide leading-zero blanking and form the next output pattern.
    always_comb begin
        nibble_s     = 4'h0;
        dp_bit_s     = 1'b0;
        blanked_s    = 1'b0;
        zero_above_s = 1'b1;
        sel_s        = '0;
        // Walk from the most significant digit downwards, so that
        // zero_above_s covers nibbles k..DIGITS-1 at the digit under test.
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above_s = zero_above_s && (active_value_r[4*k +: 4] == 4'h0);
            if (digit_r == DW'(k)) begin
                nibble_s  = active_value_r[4*k +: 4];
                dp_bit_s  = active_dp_r[k];
                blanked_s = blank_lz && (k != 0) && zero_above_s;
                sel_s[k]  = 1'b1;
            end else begin
                sel_s[k]  = 1'b0;
            end
        end

        window_s = enable && (substep_r != 4'h0) && (substep_r <= brightness);

        if (window_s && !blanked_s) begin
            seg_next_s = hex_to_seg(nibble_s);
            dp_next_s  = dp_bit_s;
            sel_on_s   = 1'b1;
        end else if (window_s && dp_bit_s) begin
            // A blanked digit still shows its decimal point.
            seg_next_s = 7'h00;
            dp_next_s  = 1'b1;
            sel_on_s   = 1'b1;
        end else begin
            seg_next_s = 7'h00;
            dp_next_s  = 1'b0;
            sel_on_s   = 1'b0;
        end
    end

    // Registered pin drivers with polarity applied, plus the end-of-frame pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segment    <= SEG_OFF;
            dp         <= DP_OFF;
            omask      <= DIG_OFF;
            frame_done <= 1'b0;
        end else begin
            segment    <= seg_next_s ^ SEG_OFF;
            dp         <= dp_next_s ^ DP_OFF;
            omask      <= (sel_on_s ? sel_s : {DIGITS{1'b0}}) ^ DIG_OFF;
            frame_done <= frame_end_s && enable;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with DIV=1 (16-cycle slot, 64-cycle frame).
// Variable n counts clock edges since the scan last restarted. Outputs sampled
// after edge n reflect scan state s = n-1.
module tb_seg7_scan_display;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        enable;
    logic        blank_lz;
    logic [3:0]  brightness;

    logic [6:0]  segment;
    logic        dp;
    logic [3:0]  omask;
    logic        frame_done;
    logic [6:0]  segment_low;
    logic        dp_low;
    logic [3:0]  omask_low;
    logic        frame_done_low;

    int checks    = 0;
    int errors    = 0;
    int n         = 0;
    int lit_count = 0;

    seg7_scan_display #(
        .DIGITS(4), .CLK_HZ(1600), .SCAN_HZ(100), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .reset(rst), .value(value), .dp_in(dp_in), .load(load),
        .enable(enable), .blank_lz(blank_lz), .brightness(brightness),
        .segment(segment), .dp(dp), .omask(omask), .frame_done(frame_done)
    );

    seg7_scan_display #(
        .DIGITS(4), .CLK_HZ(1600), .SCAN_HZ(100), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) u_low (
        .clk(clk), .reset(rst), .value(value), .dp_in(dp_in), .load(load),
        .enable(enable), .blank_lz(blank_lz), .brightness(brightness),
        .segment(segment_low), .dp(dp_low), .omask(omask_low), .frame_done(frame_done_low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    // exp_seg packs {d3,d2,d1,d0} segment patterns. exp_on says whether the digit
    // select is asserted inside the lit window. exp_dp gives each digit's decimal point.
    task automatic run_check(input int cycles, input logic [27:0] exp_seg,
                             input logic [3:0] exp_on, input logic [3:0] exp_dp);
        int s;
        int d;
        int sub;
        logic win;
        logic [3:0] e_om;
        logic [6:0] e_seg;
        logic e_dp;
        logic e_fd;
        for (int i = 0; i < cycles; i++) begin
            step();
            s   = n - 1;
            d   = (s / 16) % 4;
            sub = s % 16;
            win = enable && (sub != 0) && (sub <= int'(brightness));
            if (win && exp_on[d]) begin
                e_om  = 4'b0001 << d;
                e_seg = exp_seg[d*7 +: 7];
                e_dp  = exp_dp[d];
            end else begin
                e_om  = 4'b0000;
                e_seg = 7'h00;
                e_dp  = 1'b0;
            end
            e_fd = ((s % 64) == 63);
            if (omask != 4'b0000) lit_count++;
            check("omask", omask, e_om);
            check("segment", segment, e_seg);
            check("dp", dp, e_dp);
            check("frame_done", frame_done, e_fd);
        end
    endtask

    task automatic check_reset_levels(input string tag);
        check({tag, "_seg"}, segment, 7'h00);
        check({tag, "_dp"}, dp, 1'b0);
        check({tag, "_omask"}, omask, 4'b0000);
        check({tag, "_fd"}, frame_done, 1'b0);
        check({tag, "_low_seg"}, segment_low, 7'h7F);
        check({tag, "_low_dp"}, dp_low, 1'b1);
        check({tag, "_low_omask"}, omask_low, 4'b1111);
        check({tag, "_low_fd"}, frame_done_low, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        value      = 16'h0000;
        dp_in      = 4'b0000;
        load       = 1'b0;
        enable     = 1'b1;
        blank_lz   = 1'b0;
        brightness = 4'd15;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_levels("reset");

        // Release: substep 0 is dark, then digit 0 lights on the second edge
        rst = 1'b0;
        n   = 0;
        run_check(2, {4{7'h3F}}, 4'hF, 4'h0);
        check("release_first_lit", omask, 4'b0001);

        // Load 12AF mid-frame: the current frame keeps showing 0000
        value = 16'h12AF;
        load  = 1'b1;
        run_check(1, {4{7'h3F}}, 4'hF, 4'h0);
        load  = 1'b0;
        run_check(61, {4{7'h3F}}, 4'hF, 4'h0);
        // Next frame shows F, A, 2, 1
        run_check(64, {7'h06, 7'h5B, 7'h77, 7'h71}, 4'hF, 4'h0);

        // Brightness 3, then 0
        brightness = 4'd3;
        lit_count  = 0;
        run_check(64, {7'h06, 7'h5B, 7'h77, 7'h71}, 4'hF, 4'h0);
        check("lit_count_b3", lit_count, 12);
        brightness = 4'd0;
        lit_count  = 0;
        run_check(64, {7'h06, 7'h5B, 7'h77, 7'h71}, 4'hF, 4'h0);
        check("lit_count_b0", lit_count, 0);

        // Leading-zero blanking on 0050 with the dp on digit 3
        brightness = 4'd15;
        blank_lz   = 1'b1;
        value      = 16'h0050;
        dp_in      = 4'b1000;
        load       = 1'b1;
        run_check(1, {7'h06, 7'h5B, 7'h77, 7'h71}, 4'hF, 4'h0);
        load       = 1'b0;
        run_check(63, {7'h06, 7'h5B, 7'h77, 7'h71}, 4'hF, 4'h0);
        lit_count  = 0;
        run_check(64, {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b1011, 4'b1000);
        check("lit_count_lz", lit_count, 45);
        blank_lz   = 1'b0;
        run_check(64, {7'h3F, 7'h3F, 7'h6D, 7'h3F}, 4'hF, 4'b1000);

        // Two loads inside one frame at digit 1: the old value stays until the boundary, and the last load wins
        run_check(20, {7'h3F, 7'h3F, 7'h6D, 7'h3F}, 4'hF, 4'b1000);
        value = 16'h1111;
        dp_in = 4'b0000;
        load  = 1'b1;
        run_check(1, {7'h3F, 7'h3F, 7'h6D, 7'h3F}, 4'hF, 4'b1000);
        load  = 1'b0;
        run_check(1, {7'h3F, 7'h3F, 7'h6D, 7'h3F}, 4'hF, 4'b1000);
        value = 16'h2222;
        load  = 1'b1;
        run_check(1, {7'h3F, 7'h3F, 7'h6D, 7'h3F}, 4'hF, 4'b1000);
        load  = 1'b0;
        run_check(41, {7'h3F, 7'h3F, 7'h6D, 7'h3F}, 4'hF, 4'b1000);
        run_check(64, {4{7'h5B}}, 4'hF, 4'h0);

        // Load on the frame-boundary cycle appears in the very next frame
        run_check(63, {4{7'h5B}}, 4'hF, 4'h0);
        value = 16'h3333;
        load  = 1'b1;
        run_check(1, {4{7'h5B}}, 4'hF, 4'h0);
        load  = 1'b0;
        run_check(64, {4{7'h4F}}, 4'hF, 4'h0);

        // Disabled: dark, no frame_done, and a load goes straight to the active buffer
        enable = 1'b0;
        value  = 16'h4444;
        load   = 1'b1;
        step();
        load   = 1'b0;
        check("dis_omask_a", omask, 4'b0000);
        check("dis_fd_a", frame_done, 1'b0);
        step();
        check("dis_omask_b", omask, 4'b0000);
        check("dis_seg_b", segment, 7'h00);
        step();
        check("dis_fd_c", frame_done, 1'b0);
        enable = 1'b1;
        n      = 0;
        run_check(64, {4{7'h66}}, 4'hF, 4'h0);
        run_check(5, {4{7'h66}}, 4'hF, 4'h0);
        check("pre_reset_lit", omask, 4'b0001);

        // Asynchronous reset mid-slot
        #2;
        rst = 1'b1;
        #1;
        check_reset_levels("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        n   = 0;
        run_check(2, {4{7'h3F}}, 4'hF, 4'h0);

        // Active-low outputs showing 8 on digit 0
        enable = 1'b0;
        value  = 16'h0008;
        load   = 1'b1;
        step();
        load   = 1'b0;
        check("low_dis_omask", omask_low, 4'b1111);
        enable = 1'b1;
        n      = 0;
        run_check(1, {7'h3F, 7'h3F, 7'h3F, 7'h7F}, 4'hF, 4'h0);
        check("low_unlit_seg", segment_low, 7'h7F);
        check("low_unlit_dp", dp_low, 1'b1);
        check("low_unlit_omask", omask_low, 4'b1111);
        run_check(1, {7'h3F, 7'h3F, 7'h3F, 7'h7F}, 4'hF, 4'h0);
        check("low_lit_seg", segment_low, 7'h00);
        check("low_lit_dp", dp_low, 1'b1);
        check("low_lit_omask", omask_low, 4'b1110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
